// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//
// Purpose: request/response bundle between the CPU-side byte-lane logic
// (master) and the mem_responder word store (slave).
//
// Handshake: the master may raise req only while busy is 0. A request is
// accepted on the rising edge where req=1 and busy=0. req seen while busy=1
// is ignored (not queued). Every accepted request produces exactly one
// single-cycle ack pulse. rdata and err are valid in the ack cycle, and rdata
// is held until the next ack. busy falls in the ack cycle, so the master may
// present the next request in that same cycle.
//
// Signals:
//   req    master->slave  request strobe
//   we     master->slave  1=write, 0=read
//   be     master->slave  byte enables, be[0]=[7:0], be[1]=[15:8]
//   addr   master->slave  byte address (addr[0] ignored)
//   wdata  master->slave  write data, lanes aligned to be
//   ack    slave->master  one-cycle completion pulse
//   rdata  slave->master  read word, or the word as written
//   busy   slave->master  request in flight
//   err    slave->master  out-of-range flag (bounds-check builds only)
// ---------------------------------------------------------------------------
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [1:0]  be;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        busy;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  ack, rdata, busy, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ack, rdata, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Purpose: RAM-side responder for the CPU memory interface. Holds a
// DEPTH x 16-bit word array with synchronous-SRAM behaviour. Reads and
// full-word writes take one edge after accept; single-byte writes are done
// as an internal read-modify-write (two edges) so the array only ever sees
// whole-word writes.
//
// Parameters:
//   DEPTH  number of 16-bit words (power of two)
//   AW     word-index width, log2(DEPTH)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   bus          mem_responder_if.slave (req/we/be/addr/wdata in,
//                ack/rdata/busy/err out)
//   state_dbg_o  current FSM state encoding (observation only)
//
// Build option:
//   MEM_BOUNDS_CHK_EN  when defined, requests with address bits above the
//                      array range perform no array access and return
//                      rdata=0 with err=1. When undefined, err is tied to 0
//                      and such addresses alias modulo DEPTH words.
//
// Array contents are not reset.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_responder_if.slave    bus,
  output logic [2:0]        state_dbg_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q,   idx_d;
  logic [1:0]    be_q,    be_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   buf_q,   buf_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          ack_q,   ack_d;

  logic [15:0]   mem_q [DEPTH];
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic [15:0]   rd_word;
  logic [15:0]   merged;
  logic          accept;

  // oob_req: the incoming address is out of range (evaluated at accept).
  // oob:     the latched request is out of range.
  logic          oob_req;
  logic          oob;

  assign accept  = (state_q == IDLE) && bus.req;
  assign rd_word = mem_q[idx_q];

  // Enabled lanes come from the write data, the rest from the word read in
  // RMW_RD.
  assign merged = {be_q[1] ? wdata_q[15:8] : buf_q[15:8],
                   be_q[0] ? wdata_q[7:0]  : buf_q[7:0]};

`ifdef MEM_BOUNDS_CHK_EN
  logic oob_q, err_q, err_d;
  logic unused_addr;

  assign oob_req     = (bus.addr >> (AW + 1)) != 16'd0;
  assign oob         = oob_q;
  assign unused_addr = bus.addr[0];

  // err is set in the ack cycle of an out-of-range request and stays until
  // the next request is accepted.
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (state_q == READ || state_q == WRITE) begin
      err_d = oob_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        oob_q <= oob_req;
      end
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_addr;

  assign oob_req     = 1'b0;
  assign oob         = 1'b0;
  assign unused_addr = ^{bus.addr[15:AW+1], bus.addr[0]};
  assign bus.err     = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State and request registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      be_q    <= 2'b00;
      wdata_q <= 16'h0000;
      buf_q   <= 16'h0000;
      rdata_q <= 16'h0000;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          idx_d   = bus.addr[AW:1];
          be_d    = bus.be;
          wdata_d = bus.wdata;
          if (!bus.we) begin
            state_d = READ;
          end else if (oob_req || bus.be == 2'b11 || bus.be == 2'b00) begin
            // Out-of-range writes take the short path: no array access, so
            // there is nothing to merge.
            state_d = WRITE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end

      READ: begin
        rdata_d = oob ? 16'h0000 : rd_word;
        ack_d   = 1'b1;
        state_d = IDLE;
      end

      WRITE: begin
        // be=00 is a no-op write that still completes and acks.
        mem_we    = (be_q != 2'b00) && !oob;
        mem_wdata = wdata_q;
        rdata_d   = oob ? 16'h0000 : wdata_q;
        ack_d     = 1'b1;
        state_d   = IDLE;
      end

      RMW_RD: begin
        buf_d   = rd_word;
        state_d = RMW_WR;
      end

      RMW_WR: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        rdata_d   = merged;
        ack_d     = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Word array. Written only from WRITE/RMW_WR; during reset the state is
  // IDLE so an interrupted operation never reaches the array.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= mem_wdata;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state_q != IDLE);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  state_dbg;

  mem_responder_if bus ();

  mem_responder #(.DEPTH(256), .AW(8)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {err, rdata} per accepted request, in acceptance order.
  logic [16:0] exp_q[$];
  logic [15:0] model[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: every ack pops one expected entry.
  // ---------------------------------------------------------------------------
  logic [16:0] sb_e;
  always @(negedge clk) begin
    if (rst_n && bus.ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack_queue", exp_q.size(), 1);
      end else begin
        sb_e = exp_q.pop_front();
        check("rdata", {16'h0, bus.rdata}, {16'h0, sb_e[15:0]});
        check("err", {31'h0, bus.err}, {31'h0, sb_e[16]});
        check("busy_at_ack", {31'h0, bus.busy}, 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: present one request as soon as busy is low, then wait for its ack
  // and check latency and busy duration. With poke set, a junk full-word
  // write request is held on the bus while busy.
  // ---------------------------------------------------------------------------
  task automatic issue(input logic w, input logic [1:0] b, input logic [15:0] a,
                       input logic [15:0] d, input logic [16:0] exp, input int lat,
                       input bit poke);
    int n;
    int bc;
    int wt;
    wt = 0;
    while (bus.busy && wt < 20) begin
      @(posedge clk); #1; wt++;
    end
    check("idle_wait", wt < 20, 1);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.be    = b;
    bus.addr  = a;
    bus.wdata = d;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.req = 1'b0;
    n  = 0;
    bc = 0;
    while (!bus.ack && n < 20) begin
      if (bus.busy) bc++;
      if (poke && bus.busy) begin
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.be    = 2'b11;
        bus.addr  = a;
        bus.wdata = 16'hdead;
      end
      @(posedge clk); #1; n++;
    end
    bus.req = 1'b0;
    check("latency", n, lat);
    check("busy_cycles", bc, lat);
  endtask

  function automatic int wr_lat(input logic [1:0] b);
    return (b == 2'b01 || b == 2'b10) ? 2 : 1;
  endfunction

  initial begin
    logic [15:0] a, d, m;
    logic [1:0]  b;
    logic        w;
    int          wi;

    bus.req = 1'b0; bus.we = 1'b0; bus.be = 2'b00; bus.addr = 16'h0; bus.wdata = 16'h0;
    rst_n = 1'b0;
    #12;
    check("reset_ack", {31'h0, bus.ack}, 32'd0);
    check("reset_busy", {31'h0, bus.busy}, 32'd0);
    check("reset_rdata", {16'h0, bus.rdata}, 32'd0);
    check("reset_err", {31'h0, bus.err}, 32'd0);
    check("reset_state", {29'h0, state_dbg}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Full write then read.
    issue(1'b1, 2'b11, 16'd4, 16'haabb, {1'b0, 16'haabb}, 1, 1'b0);
    issue(1'b0, 2'b11, 16'd4, 16'h0000, {1'b0, 16'haabb}, 1, 1'b0);
    // Low-byte RMW and readback.
    issue(1'b1, 2'b01, 16'd4, 16'h0011, {1'b0, 16'haa11}, 2, 1'b0);
    issue(1'b0, 2'b00, 16'd5, 16'h0000, {1'b0, 16'haa11}, 1, 1'b0);
    // High-byte RMW, then be=00 no-op write, readback unchanged.
    issue(1'b1, 2'b10, 16'd4, 16'h2200, {1'b0, 16'h2211}, 2, 1'b0);
    issue(1'b1, 2'b00, 16'd4, 16'hffff, {1'b0, 16'hffff}, 1, 1'b0);
    issue(1'b0, 2'b11, 16'd4, 16'h0000, {1'b0, 16'h2211}, 1, 1'b0);
    // Back-to-back: the read is presented in the write's ack cycle.
    issue(1'b1, 2'b11, 16'd6, 16'h5a5a, {1'b0, 16'h5a5a}, 1, 1'b0);
    issue(1'b0, 2'b11, 16'd6, 16'h0000, {1'b0, 16'h5a5a}, 1, 1'b0);
    // Request held during RMW busy must be ignored.
    issue(1'b1, 2'b01, 16'd4, 16'h00cc, {1'b0, 16'h22cc}, 2, 1'b1);
    issue(1'b0, 2'b11, 16'd4, 16'h0000, {1'b0, 16'h22cc}, 1, 1'b0);
    // Same-word RMW immediately after a full write.
    issue(1'b1, 2'b11, 16'd8, 16'h1357, {1'b0, 16'h1357}, 1, 1'b0);
    issue(1'b1, 2'b10, 16'd8, 16'hab00, {1'b0, 16'hab57}, 2, 1'b0);

    // Reset while in RMW_RD: operation aborted, word 2 unchanged.
    bus.req = 1'b1; bus.we = 1'b1; bus.be = 2'b10; bus.addr = 16'd4; bus.wdata = 16'h9900;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("rmw_rd_entered", {29'h0, state_dbg}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'h0, bus.ack}, 32'd0);
    check("midrst_busy", {31'h0, bus.busy}, 32'd0);
    check("midrst_rdata", {16'h0, bus.rdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 2'b11, 16'd4, 16'h0000, {1'b0, 16'h22cc}, 1, 1'b0);

    // Out-of-range address.
    issue(1'b1, 2'b11, 16'd0, 16'h1234, {1'b0, 16'h1234}, 1, 1'b0);
`ifdef MEM_BOUNDS_CHK_EN
    issue(1'b0, 2'b11, 16'h0200, 16'h0000, {1'b1, 16'h0000}, 1, 1'b0);
    issue(1'b1, 2'b01, 16'h0200, 16'h00ee, {1'b1, 16'h0000}, 1, 1'b0);
`else
    issue(1'b0, 2'b11, 16'h0200, 16'h0000, {1'b0, 16'h1234}, 1, 1'b0);
`endif
    issue(1'b0, 2'b11, 16'd0, 16'h0000, {1'b0, 16'h1234}, 1, 1'b0);

    // Random traffic on words 16..23, preloaded first so RMW merges known data.
    for (int k = 16; k < 24; k++) begin
      d = 16'($urandom_range(0, 65535));
      model[k] = d;
      issue(1'b1, 2'b11, 16'(k * 2), d, {1'b0, d}, 1, 1'b0);
    end
    for (int i = 0; i < 24; i++) begin
      wi = $urandom_range(16, 23);
      a  = 16'(wi * 2 + $urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      b  = 2'($urandom_range(0, 3));
      d  = 16'($urandom_range(0, 65535));
      if (!w) begin
        issue(1'b0, b, a, d, {1'b0, model[wi]}, 1, 1'b0);
      end else begin
        m = {b[1] ? d[15:8] : model[wi][15:8], b[0] ? d[7:0] : model[wi][7:0]};
        if (b == 2'b11) m = d;
        if (b != 2'b00) model[wi] = m;
        issue(1'b1, b, a, d, {1'b0, (b == 2'b00) ? d : m}, wr_lat(b), 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- RAM-side responder for the CPU memory interface: accepts word/byte requests carrying a byte address, byte enables, write enable and write data, and returns the read word.
- Holds a DEPTH x 16-bit word array that behaves like a synchronous SRAM.
- Full-word writes complete in one access.
- Single-byte writes are done as an internal read-modify-write, so the array never needs per-byte write strobes.
- Sits between the memory_io byte-lane logic and the storage array; its rdata feeds memory_io's RAMread.

Parameters:
- DEPTH, 256, number of 16-bit words in the array (power of two).
- AW, 8, word-index width; log2(DEPTH).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  1  request strobe; sampled only when busy=0
- we  input  1  1=write, 0=read; sampled with req
- be  input  2  byte enables; be[0]=low byte [7:0], be[1]=high byte [15:8]
- addr  input  16  byte address; word index = addr[AW:1], addr[0] ignored
- wdata  input  16  write data, lanes aligned to be
- ack  output  1  one-cycle completion pulse
- rdata  output  16  read word (reads) or word as written (writes); held until next ack
- busy  output  1  high while a request is in flight
- err  output  1  error flag, valid with ack (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack=0, rdata=16'h0000, busy=0, err=0, latched request cleared. Array contents are not reset.
- FSM states: IDLE, READ, WRITE, RMW_RD, RMW_WR. busy = (state != IDLE), combinational from state.
- IDLE, req=1: latch addr/be/we/wdata on this edge, then:
  - we=0 -> READ
  - we=1, be=11 -> WRITE
  - we=1, be=01 or 10 -> RMW_RD
  - we=1, be=00 -> WRITE with the array write suppressed (no-op write that still acks)
- READ: mem[idx] is copied to rdata, ack<=1, next state IDLE. Reads always return the full word regardless of be.
- WRITE: mem[idx]<=wdata (unless be=00), rdata<=wdata, ack<=1, next state IDLE.
- RMW_RD: buf<=mem[idx], next state RMW_WR.
- RMW_WR: merged = enabled lanes taken from wdata, other lanes from buf. mem[idx]<=merged, rdata<=merged, ack<=1, next state IDLE.
- Latency, counted in edges after the accept edge until ack is high: READ 1, WRITE 1, RMW 2.
- ack is high for exactly one cycle. In that cycle the state is already IDLE, so a new req in the ack cycle is accepted (back-to-back, no bubble).
- req while busy=1 is ignored: not queued, no effect. The requester must wait for busy=0.
- Same-word RMW immediately after a write: the read sees the just-written data, because the array write completes on the prior edge.
- Reset asserted mid-operation: the operation is aborted and no ack is produced. The array write happens only on the WRITE/RMW_WR edge; if reset lands before that edge, memory is unchanged.
- Address wrap: idx = addr[AW:1], upper bits are discarded unless BOUNDS_CHK_EN is defined.

Optional Feature:
- Macro: MEM_BOUNDS_CHK_EN.
- Defined:
  - A request with addr[15:AW+1] != 0 goes IDLE -> READ/WRITE path timing but performs no array access.
  - It returns rdata=16'h0000 with err=1 in the ack cycle; err is otherwise 0.
  - err is cleared on the next accepted request.
- Not defined: err is tied to 0 and out-of-range addresses alias modulo DEPTH words.

Test Plan:
- Full write then read: write addr=4, be=11, wdata=16'haabb -> ack 1 edge after accept, rdata=aabb. Then read addr=4 -> ack 1 edge later, rdata=16'haabb, busy high exactly 1 cycle for each.
- Low-byte RMW: preload word 2 = 16'haabb. Write addr=4, be=01, wdata=16'h0011 -> busy 2 cycles, ack on 2nd edge, rdata=16'haa11. Readback 16'haa11.
- High-byte RMW plus be=00: write addr=4, be=10, wdata=16'h2200 -> rdata=16'h2211. Then write be=00, wdata=16'hffff -> ack after 1 edge, readback still 16'h2211.
- Back-to-back and ignored req:
  - Issue a read in the same cycle ack is high -> accepted, second ack 1 edge later.
  - Pulse req during RMW busy -> no extra ack, memory unchanged.
- Reset mid-RMW: assert reset=0 while in RMW_RD -> ack=0, rdata=0, busy=0 immediately; the target word keeps its old value on later readback.
- With MEM_BOUNDS_CHK_EN defined, DEPTH=256: read addr=16'h0200 -> ack with err=1, rdata=0, word 0 untouched. Without the macro: same address reads word 0, err=0.
